// File: rtl/lif_pkg.sv
// lif_pkg: shared definitions for the LIF neuron array.
//   lif_state_e : sweep FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   sat_signed  : clamp a wide signed value into a w-bit two's complement range
//   leak_of     : membrane leak term, V >>> shift
// Helpers operate on 64-bit signed values so one definition serves any W up to 62.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } lif_state_e;

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end else begin
      return x;
    end
  endfunction

  function automatic logic signed [63:0] leak_of(input logic signed [63:0] v,
                                                 input int unsigned shift);
    return v >>> shift;
  endfunction

endpackage

// File: rtl/lif_update.sv
// lif_update: combinational single-neuron update.
// Ports:
//   v, refrac                  : current membrane potential and refractory counter
//   cur_data                   : input current for this neuron
//   threshold, reset_potential : firing threshold and post-spike potential
//   v_next, refrac_next        : values to write back
//   fire                       : neuron spikes on this update
// A refractory neuron only counts down; its input current is dropped.
module lif_update
  import lif_pkg::*;
#(
  parameter int W          = 16,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2,
  parameter int RC_W       = 2
) (
  input  logic signed [W-1:0] v,
  input  logic [RC_W-1:0]     refrac,
  input  logic signed [W-1:0] cur_data,
  input  logic signed [W-1:0] threshold,
  input  logic signed [W-1:0] reset_potential,
  output logic signed [W-1:0] v_next,
  output logic [RC_W-1:0]     refrac_next,
  output logic                fire
);

  logic signed [W-1:0]   leak;
  logic signed [W+1:0]   sum;
  logic signed [W-1:0]   sat_sum;

  always_comb begin
    leak = W'(leak_of({{(64-W){v[W-1]}}, v}, LEAK_SHIFT));
    // Two guard bits cover V - leak + cur for any pair of W-bit operands.
    sum = {{2{v[W-1]}}, v} - {{2{leak[W-1]}}, leak} + {{2{cur_data[W-1]}}, cur_data};
    sat_sum = W'(sat_signed({{(64-W-2){sum[W+1]}}, sum}, W));

    v_next      = v;
    refrac_next = refrac;
    fire        = 1'b0;
    if (refrac != '0) begin
      refrac_next = refrac - RC_W'(1);
    end else if (sat_sum >= threshold) begin
      v_next      = reset_potential;
      refrac_next = RC_W'(REFRAC);
      fire        = 1'b1;
    end else begin
      v_next = sat_sum;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: time-multiplexed leaky integrate-and-fire neuron array.
// One neuron is updated per accepted current; step_start launches a sweep
// over all N_NEURONS neurons in index order.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   threshold, reset_potential    : signed firing threshold / post-spike potential
//   clear                         : zero all potentials and refractory counters (IDLE only)
//   step_start, busy, step_done   : sweep control and status
//   cur_valid/cur_ready/cur_data  : per-neuron current stream, neuron cur_idx
//   spk_valid/spk_ready/spk_idx   : spike event stream
//   spike_count                   : spikes in the current/last step
// Optional feature: define LIF_SPIKE_COUNT_EN to add the spike_count port and counter.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = 16,
  parameter int W          = 16,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2,
  localparam int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic signed [W-1:0] threshold,
  input  logic signed [W-1:0] reset_potential,
  input  logic                clear,
  input  logic                step_start,
  output logic                busy,
  output logic                step_done,
  input  logic                cur_valid,
  output logic                cur_ready,
  input  logic signed [W-1:0] cur_data,
  output logic [IDX_W-1:0]    cur_idx,
  output logic                spk_valid,
  input  logic                spk_ready,
  output logic [IDX_W-1:0]    spk_idx
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [IDX_W:0]      spike_count
`endif
);

  localparam int RC_W = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);

  lif_state_e          state;
  logic signed [W-1:0] v_mem  [N_NEURONS];
  logic [RC_W-1:0]     rc_mem [N_NEURONS];

  logic                cur_hs;
  logic                last_idx;
  logic signed [W-1:0] v_upd;
  logic [RC_W-1:0]     rc_upd;
  logic                fire;

  // A held (unaccepted) spike blocks further updates so no event is lost.
  assign cur_ready = (state == ST_RUN) & ~(spk_valid & ~spk_ready);
  assign cur_hs    = cur_valid & cur_ready;
  assign busy      = (state != ST_IDLE);
  assign step_done = (state == ST_DONE);
  assign last_idx  = (cur_idx == IDX_W'(N_NEURONS - 1));

  lif_update #(
    .W          (W),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRAC     (REFRAC),
    .RC_W       (RC_W)
  ) u_update (
    .v               (v_mem[cur_idx]),
    .refrac          (rc_mem[cur_idx]),
    .cur_data        (cur_data),
    .threshold       (threshold),
    .reset_potential (reset_potential),
    .v_next          (v_upd),
    .refrac_next     (rc_upd),
    .fire            (fire)
  );

  // Sweep control
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cur_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (step_start) begin
            state   <= ST_RUN;
            cur_idx <= '0;
          end
        end
        ST_RUN: begin
          if (cur_hs) begin
            if (last_idx) begin
              state   <= ST_DRAIN;
              cur_idx <= '0;
            end else begin
              cur_idx <= cur_idx + IDX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // Hold step_done back until the final spike has left.
          if (!spk_valid || spk_ready) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Spike output register: a new spike may replace one accepted this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spk_valid <= 1'b0;
      spk_idx   <= '0;
    end else if (cur_hs && fire) begin
      spk_valid <= 1'b1;
      spk_idx   <= cur_idx;
    end else if (spk_valid && spk_ready) begin
      spk_valid <= 1'b0;
    end
  end

  // Neuron state arrays
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i]  <= '0;
        rc_mem[i] <= '0;
      end
    end else if ((state == ST_IDLE) && clear) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i]  <= '0;
        rc_mem[i] <= '0;
      end
    end else if (cur_hs) begin
      v_mem[cur_idx]  <= v_upd;
      rc_mem[cur_idx] <= rc_upd;
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spike_count <= '0;
    end else if ((state == ST_IDLE) && step_start) begin
      spike_count <= '0;
    end else if (cur_hs && fire) begin
      spike_count <= spike_count + (IDX_W+1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array: self-checking bench for lif_neuron_array (N=4, W=16,
// LEAK_SHIFT=3, REFRAC=2). A behavioural model predicts, per timestep, which
// neurons fire; the bench drives randomized handshakes and checks the streams.
module tb_lif_neuron_array;

  localparam int N = 4;

  logic               clk;
  logic               reset_n;
  logic signed [15:0] threshold;
  logic signed [15:0] reset_potential;
  logic               clear;
  logic               step_start;
  logic               busy;
  logic               step_done;
  logic               cur_valid;
  logic               cur_ready;
  logic signed [15:0] cur_data;
  logic [1:0]         cur_idx;
  logic               spk_valid;
  logic               spk_ready;
  logic [1:0]         spk_idx;
`ifdef LIF_SPIKE_COUNT_EN
  logic [2:0]         spike_count;
`endif

  lif_neuron_array #(
    .N_NEURONS  (N),
    .W          (16),
    .LEAK_SHIFT (3),
    .REFRAC     (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .threshold       (threshold),
    .reset_potential (reset_potential),
    .clear           (clear),
    .step_start      (step_start),
    .busy            (busy),
    .step_done       (step_done),
    .cur_valid       (cur_valid),
    .cur_ready       (cur_ready),
    .cur_data        (cur_data),
    .cur_idx         (cur_idx),
    .spk_valid       (spk_valid),
    .spk_ready       (spk_ready),
    .spk_idx         (spk_idx)
`ifdef LIF_SPIKE_COUNT_EN
    ,
    .spike_count     (spike_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: membrane potentials, refractory counters, step inputs.
  int mv [N];
  int mrc[N];
  int cv [N];
  int th;
  int rp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < N; i++) begin
      mv[i]  = 0;
      mrc[i] = 0;
    end
  endtask

  // One timestep of the LIF rules with plain integer arithmetic.
  task automatic model_step(output logic [3:0] mask);
    mask = '0;
    for (int i = 0; i < N; i++) begin
      int s;
      if (mrc[i] != 0) begin
        mrc[i] = mrc[i] - 1;
      end else begin
        s = mv[i] - (mv[i] >>> 3) + cv[i];
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (s >= th) begin
          mask[i] = 1'b1;
          mv[i]   = rp;
          mrc[i]  = 2;
        end else begin
          mv[i] = s;
        end
      end
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_zero();
  endtask

  // Run one full timestep with optional random backpressure/gaps; hold!=0 forces
  // spk_ready low for three cycles on the first spike seen mid-sweep.
  task automatic run_step(input int hold, input int stall_pct, input int gap_pct,
                          output logic [3:0] got);
    logic [3:0] exp_mask;
    int         hs, cyc, done_at, stall_left, exp_idx, fires_seen;
    bit         done_seen, hold_used, exp_fire_next, prev_stall;
    logic [1:0] prev_idx;
    model_step(exp_mask);
    got = '0; hs = 0; cyc = 0; done_at = -1; stall_left = 0; exp_idx = 0;
    fires_seen = 0; done_seen = 0; hold_used = 0; exp_fire_next = 0;
    prev_stall = 0; prev_idx = '0;
    threshold       = 16'(th);
    reset_potential = 16'(rp);
    @(negedge clk);
    step_start = 1'b1; cur_valid = 1'b0; spk_ready = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    while (!done_seen && cyc < 300) begin
      if (cyc > 0) @(negedge clk);
      if (hold != 0 && !hold_used && spk_valid === 1'b1 && hs < N) begin
        stall_left = 3;
        hold_used  = 1;
      end
      if (stall_left > 0) begin
        spk_ready  = 1'b0;
        stall_left = stall_left - 1;
      end else begin
        spk_ready = (hs >= N) || ($urandom_range(99) >= stall_pct);
      end
      cur_valid = (hs < N) && ($urandom_range(99) >= gap_pct);
      cur_data  = (hs < N) ? 16'(cv[hs]) : 16'sd0;
      #1;
      chk("busy_run", busy, 1);
      chk("spk_valid", spk_valid, exp_fire_next || prev_stall);
      if (exp_fire_next) chk("spk_idx_new", spk_idx, exp_idx);
      if (prev_stall) chk("spk_idx_hold", spk_idx, prev_idx);
      chk("cur_idx", cur_idx, (hs < N) ? hs : 0);
      chk("cur_ready", cur_ready, (hs < N) && !(spk_valid && !spk_ready));
      chk("step_done", step_done, cyc == done_at);
      if (step_done === 1'b1) begin
        done_seen = 1;
`ifdef LIF_SPIKE_COUNT_EN
        chk("spike_count", spike_count, $countones(exp_mask));
`endif
      end
      exp_fire_next = 0;
      if (spk_valid === 1'b1 && spk_ready) begin
        fires_seen++;
        got[spk_idx] = 1'b1;
      end
      prev_stall = (spk_valid === 1'b1) && !spk_ready;
      prev_idx   = spk_idx;
      if (cur_valid && cur_ready === 1'b1) begin
        exp_fire_next = exp_mask[hs];
        exp_idx       = hs;
        hs++;
        if (hs == N) done_at = cyc + 2;
      end
      cyc++;
    end
    chk("step_done_seen", done_seen, 1);
    chk("spike_mask", got, exp_mask);
    chk("spike_total", fires_seen, $countones(exp_mask));
    @(negedge clk);
    cur_valid = 1'b0;
    #1;
    chk("busy_off", busy, 0);
    chk("done_off", step_done, 0);
    chk("spk_idle", spk_valid, 0);
  endtask

  initial begin
    logic [3:0] got;
    int         k;
    reset_n = 1'b0; threshold = '0; reset_potential = '0; clear = 1'b0;
    step_start = 1'b0; cur_valid = 1'b0; cur_data = '0; spk_ready = 1'b1;
    model_zero();
    for (int i = 0; i < N; i++) cv[i] = 0;
    th = 100; rp = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_step_done", step_done, 0);
    chk("rst_spk_valid", spk_valid, 0);
    chk("rst_spk_idx", spk_idx, 0);
    chk("rst_cur_idx", cur_idx, 0);
    chk("rst_cur_ready", cur_ready, 0);
`ifdef LIF_SPIKE_COUNT_EN
    chk("rst_spike_count", spike_count, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // Integration and refractory: neuron 0 fires on step 3, silent 4-5, V=40 at 6.
    cv[0] = 40; cv[1] = 0; cv[2] = 0; cv[3] = 0;
    for (int s = 0; s < 7; s++) begin
      run_step(0, 0, 0, got);
      chk($sformatf("integ_s%0d", s + 1), got, (s == 2) ? 4'b0001 : 4'b0000);
    end

    // Saturation: 30000 then 56250 clamps to 32767 and meets threshold 0x7FFF.
    do_clear();
    th = 32767;
    cv[0] = 0; cv[1] = 30000;
    run_step(0, 0, 0, got);
    chk("sat_s1", got, 4'b0000);
    run_step(0, 0, 0, got);
    chk("sat_s2", got, 4'b0010);

    // Negative leak: -8000, -15000, then 13225 lands exactly on threshold 100.
    do_clear();
    th = 100;
    cv[1] = 0; cv[2] = -8000;
    run_step(0, 0, 0, got);
    chk("neg_s1", got, 4'b0000);
    run_step(0, 0, 0, got);
    chk("neg_s2", got, 4'b0000);
    cv[2] = 13225;
    run_step(0, 0, 0, got);
    chk("neg_s3_eq_thresh", got, 4'b0100);

    // Backpressure: neuron 1 spike held for three cycles mid-sweep.
    do_clear();
    cv[0] = 0; cv[1] = 200; cv[2] = 0; cv[3] = 0;
    run_step(1, 0, 0, got);
    chk("bp_mask", got, 4'b0010);

    // Reset mid-sweep at cur_idx = 2.
    @(negedge clk);
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0; cur_valid = 1'b1; cur_data = 16'sd500; spk_ready = 1'b1;
    k = 0;
    while (cur_idx !== 2'd2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reach_idx2", cur_idx, 2);
    reset_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_cur_idx", cur_idx, 0);
    chk("mid_cur_ready", cur_ready, 0);
    chk("mid_spk_valid", spk_valid, 0);
    chk("mid_step_done", step_done, 0);
    @(negedge clk);
    reset_n = 1'b1; cur_valid = 1'b0;
    model_zero();
    for (int i = 0; i < N; i++) cv[i] = 40;
    run_step(0, 0, 0, got);
    chk("mid_after_s1", got, 4'b0000);
    run_step(0, 0, 0, got);
    chk("mid_after_s2", got, 4'b0000);
    run_step(0, 0, 0, got);
    chk("mid_after_s3", got, 4'b1111);

    // Randomized timesteps with stalls, gaps and occasional clears.
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(7) == 0) do_clear();
      th = int'($urandom_range(20000));
      rp = int'($urandom_range(1000)) - 500;
      for (int i = 0; i < N; i++) begin
        if (s % 4 == 3) cv[i] = int'($signed(16'($urandom)));
        else            cv[i] = int'($urandom_range(24000)) - 12000;
      end
      run_step(0, 30, 20, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
